// File: rtl/fft_peak_find.sv
// Scans bins 1 .. N/2-1 of a finished FFT frame, one bin per clock, and reports
// the bin with the largest Re^2 + Im^2 (lowest index wins ties).
module fft_peak_find #(
    parameter int bit_width  = 16,
    parameter int N          = 512,
    parameter int addr_width = 9
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [2*bit_width-1:0]   threshold,
    output logic                     rd_en,
    output logic [addr_width-1:0]    rd_addr,
    input  logic [2*bit_width-1:0]   rd_data,
    output logic                     busy,
    output logic                     done,
    output logic [addr_width-1:0]    peak_bin,
    output logic [2*bit_width-1:0]   peak_mag,
    output logic                     peak_valid
);

    localparam int mag_width = 2 * bit_width;
    localparam logic [addr_width-1:0] last_bin = addr_width'(N / 2 - 1);

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

    state_t state;
    state_t state_next;

    logic                  accept;
    logic                  data_valid_q;
    logic [addr_width-1:0] data_bin_q;
    logic                  first_q;
    logic [mag_width-1:0]  thr_q;
    logic [mag_width-1:0]  max_mag;
    logic [addr_width-1:0] max_bin;

    logic [mag_width-1:0]  re_ext;
    logic [mag_width-1:0]  im_ext;
    logic [mag_width-1:0]  cur_mag;
    logic                  take;
    logic [mag_width-1:0]  final_mag;
    logic [addr_width-1:0] final_bin;

    assign accept = (state == IDLE) && start;
    assign rd_en  = (state == SCAN);
    assign busy   = (state != IDLE);
    assign done   = (state == DONE);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // NOTE: defaults first so no path through the block leaves a signal unassigned (no latch).
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = SCAN;
            SCAN:    if (rd_addr == last_bin) state_next = DRAIN;
            DRAIN:   state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Squares of sign-extended components fit the low mag_width bits exactly:
    // the largest possible sum is 2^(mag_width-1), so dropping the carry loses nothing.
    always_comb begin
        re_ext  = {{bit_width{rd_data[mag_width-1]}}, rd_data[mag_width-1:bit_width]};
        im_ext  = {{bit_width{rd_data[bit_width-1]}}, rd_data[bit_width-1:0]};
        cur_mag = re_ext * re_ext + im_ext * im_ext;
    end

    // Strictly-greater replacement keeps the earliest bin on ties; bin 1 loads unconditionally.
    always_comb begin
        take      = data_valid_q && (first_q || (cur_mag > max_mag));
        final_mag = take ? cur_mag : max_mag;
        final_bin = take ? data_bin_q : max_bin;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_addr      <= '0;
            data_valid_q <= 1'b0;
            data_bin_q   <= '0;
            first_q      <= 1'b0;
            thr_q        <= '0;
            max_mag      <= '0;
            max_bin      <= '0;
            peak_bin     <= '0;
            peak_mag     <= '0;
            peak_valid   <= 1'b0;
        end else begin
            data_valid_q <= rd_en;
            data_bin_q   <= rd_addr;

            if (accept) begin
                rd_addr <= addr_width'(1);
                thr_q   <= threshold;
                first_q <= 1'b1;
            end else if (state == SCAN) begin
                rd_addr <= (rd_addr == last_bin) ? '0 : rd_addr + addr_width'(1);
            end

            if (data_valid_q) begin
                first_q <= 1'b0;
                max_mag <= final_mag;
                max_bin <= final_bin;
            end

            // The last datum arrives in DRAIN, so the result is folded in on the way to DONE.
            if (state == DRAIN) begin
                peak_bin   <= final_bin;
                peak_mag   <= final_mag;
                peak_valid <= (final_mag >= thr_q);
            end
        end
    end

endmodule

// File: tb/tb_fft_peak_find.sv
// Directed bench for fft_peak_find: RAM model, frame-level reference model and
// a per-cycle compare process, plus literal expectations for each scenario.
module tb_fft_peak_find;

    localparam int BW = 16;
    localparam int NN = 512;
    localparam int AW = 9;
    localparam int M  = NN / 2 - 1;
    localparam int DONE_CYC = M + 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [31:0]   threshold = '0;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [31:0]   rd_data = '0;
    logic          busy;
    logic          done;
    logic [AW-1:0] peak_bin;
    logic [31:0]   peak_mag;
    logic          peak_valid;

    int checks = 0;
    int errors = 0;

    logic [31:0] ram [0:NN-1];

    // Frame-level reference: cycle index since the accepted start (0 = idle).
    int     scan_cyc = 0;
    longint thr_l = 0;
    int     res_bin = 0;
    longint res_mag = 0;
    int     exp_bin = 0;
    longint exp_mag = 0;
    logic   exp_valid = 1'b0;

    fft_peak_find #(.bit_width(BW), .N(NN), .addr_width(AW)) dut (
        .clk(clk), .reset(reset), .start(start), .threshold(threshold),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .busy(busy), .done(done), .peak_bin(peak_bin),
        .peak_mag(peak_mag), .peak_valid(peak_valid)
    );

    always #5 clk = ~clk;

    // One-cycle-latency RAM; outside read cycles it returns a huge value that must be ignored.
    always @(posedge clk) rd_data <= rd_en ? ram[rd_addr] : 32'h8000_8000;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] pack(input int re, input int im);
        logic [31:0] r = re;
        logic [31:0] i = im;
        return {r[15:0], i[15:0]};
    endfunction

    function automatic void model_peak(output int bin, output longint mag);
        longint re, im, m;
        mag = -1;
        bin = 0;
        for (int k = 1; k <= M; k++) begin
            re = $signed(ram[k][31:16]);
            im = $signed(ram[k][15:0]);
            m  = re * re + im * im;
            if (m > mag) begin
                mag = m;
                bin = k;
            end
        end
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            scan_cyc  = 0;
            exp_bin   = 0;
            exp_mag   = 0;
            exp_valid = 1'b0;
        end else if (scan_cyc == 0) begin
            if (start) begin
                scan_cyc = 1;
                thr_l    = threshold;
                model_peak(res_bin, res_mag);
            end
        end else if (scan_cyc == DONE_CYC) begin
            scan_cyc = 0;
        end else begin
            scan_cyc++;
            if (scan_cyc == DONE_CYC) begin
                exp_bin   = res_bin;
                exp_mag   = res_mag;
                exp_valid = (res_mag >= thr_l);
            end
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            check("busy", busy, scan_cyc >= 1);
            check("done", done, scan_cyc == DONE_CYC);
            check("rd_en", rd_en, scan_cyc >= 1 && scan_cyc <= M);
            if (rd_en) check("rd_addr", rd_addr, scan_cyc);
            check("peak_bin", peak_bin, exp_bin);
            check("peak_mag", peak_mag, exp_mag);
            check("peak_valid", peak_valid, exp_valid);
        end
    end

    task automatic clear_ram();
        for (int i = 0; i < NN; i++) ram[i] = '0;
    endtask

    // Pulses start, then scrambles threshold to show it is latched; returns the done cycle or -1.
    task automatic run_scan(input logic [31:0] thr, output int done_cyc);
        @(negedge clk);
        threshold = thr;
        start     = 1'b1;
        done_cyc  = -1;
        for (int c = 1; c <= 400; c++) begin
            @(negedge clk);
            start     = 1'b0;
            threshold = 32'hFFFF_FFFF;
            if (done) begin
                done_cyc = c;
                break;
            end
        end
    endtask

    initial begin
        int dc;
        int dn;
        clear_ram();
        repeat (2) @(negedge clk);
        check("reset rd_en", rd_en, 0);
        check("reset rd_addr", rd_addr, 0);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset peak_bin", peak_bin, 0);
        check("reset peak_mag", peak_mag, 0);
        check("reset peak_valid", peak_valid, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Single tone
        ram[37] = pack(1000, -500);
        run_scan(32'd0, dc);
        check("tone done_cyc", dc, 257);
        check("tone peak_bin", peak_bin, 37);
        check("tone peak_mag", peak_mag, 1250000);
        check("tone peak_valid", peak_valid, 1);

        // DC and upper half ignored
        clear_ram();
        ram[0]   = pack(32767, 32767);
        ram[300] = pack(30000, 0);
        ram[12]  = pack(100, 0);
        run_scan(32'd0, dc);
        check("dc done_cyc", dc, 257);
        check("dc peak_bin", peak_bin, 12);
        check("dc peak_mag", peak_mag, 10000);

        // Tie at the most negative components
        clear_ram();
        ram[10] = pack(-32768, -32768);
        ram[20] = pack(-32768, -32768);
        run_scan(32'd0, dc);
        check("tie peak_bin", peak_bin, 10);
        check("tie peak_mag", peak_mag, 32'h8000_0000);

        // All zero with threshold 1, then 0
        clear_ram();
        run_scan(32'd1, dc);
        check("zero thr1 peak_bin", peak_bin, 1);
        check("zero thr1 peak_mag", peak_mag, 0);
        check("zero thr1 peak_valid", peak_valid, 0);
        run_scan(32'd0, dc);
        check("zero thr0 peak_valid", peak_valid, 1);

        // Start while busy and in the DONE cycle
        ram[37] = pack(1000, -500);
        @(negedge clk);
        threshold = 32'd0;
        start     = 1'b1;
        dn = 0;
        dc = -1;
        for (int c = 1; c <= 300; c++) begin
            @(negedge clk);
            start = (c == 50 || c == 257);
            if (done) begin
                dn++;
                dc = c;
            end
            if (c == 258) check("busy after done", busy, 0);
        end
        start = 1'b0;
        check("busy-start done count", dn, 1);
        check("busy-start done_cyc", dc, 257);
        check("busy-start peak_bin", peak_bin, 37);

        // Reset mid-scan
        clear_ram();
        ram[37] = pack(1000, -500);
        run_scan(32'd0, dc);
        check("pre-reset peak_bin", peak_bin, 37);
        @(negedge clk);
        start = 1'b1;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        #2 reset = 1'b1;
        #1;
        check("abort rd_en", rd_en, 0);
        check("abort rd_addr", rd_addr, 0);
        check("abort busy", busy, 0);
        check("abort done", done, 0);
        check("abort peak_bin", peak_bin, 0);
        check("abort peak_mag", peak_mag, 0);
        check("abort peak_valid", peak_valid, 0);
        @(negedge clk);
        #2 reset = 1'b0;
        dn = 0;
        repeat (300) begin
            @(negedge clk);
            if (done) dn++;
        end
        check("no done after abort", dn, 0);
        run_scan(32'd0, dc);
        check("after abort done_cyc", dc, 257);
        check("after abort peak_bin", peak_bin, 37);
        check("after abort peak_mag", peak_mag, 1250000);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/fft_peak_find.md
# fft_peak_find

Reads one completed FFT frame from the FFT output RAM, one bin per cycle. For each bin it computes the squared magnitude Re² + Im², using the same arithmetic as the tuner's magnitude path. It reports the bin with the largest squared magnitude over the positive-frequency half, excluding DC. It sits between the FFT core's result memory and the note/pitch decoder, and is started once per frame after the FFT signals completion.

## Interface
- `bit_width`, 16, width of each signed Re/Im component
- `N`, 512, FFT length (power of two)
- `addr_width`, 9, log2(N)
- `clk`  in  1  system clock; all state changes on the rising edge
- `reset`  in  1  asynchronous, active-high; one clock
- `start`  in  1  single-cycle request to scan a frame; honoured only in IDLE
- `threshold`  in  2*bit_width  minimum peak magnitude² for `peak_valid`; sampled on the accepted `start`
- `rd_en`  out  1  read strobe to FFT RAM
- `rd_addr`  out  addr_width  bin address to FFT RAM
- `rd_data`  in  2*bit_width  {Re, Im}, Re in the upper half; valid the cycle after `rd_en`/`rd_addr`
- `busy`  out  1  high from the cycle after an accepted `start` through the DONE cycle
- `done`  out  1  single-cycle pulse; `peak_*` outputs are updated in this cycle
- `peak_bin`  out  addr_width  index of the maximum bin
- `peak_mag`  out  2*bit_width  its magnitude², unsigned
- `peak_valid`  out  1  `peak_mag >= threshold` (latched `threshold`)

## Operation
- **Scan range:** bins 1 .. M, where M = N/2 − 1.
  - Bin 0 (DC) and bins ≥ N/2 are never read.
- **Magnitude arithmetic:**
  - Re and Im are signed `bit_width`.
  - Each square is 2*bit_width unsigned; the sum is computed at 2*bit_width+1 and truncated to 2*bit_width.
  - The truncation is exact for all inputs: the maximum sum is 2·(2^(bit_width−1))² = 2^(2*bit_width−1).
- **Running maximum:**
  - The first bin read (bin 1) loads unconditionally.
  - Later bins replace the running maximum only if strictly greater.
  - On ties the lowest bin index wins.
- **States:**
  - IDLE: `start` → SCAN.
  - SCAN: issue `rd_en=1`, `rd_addr` = 1 .. M on consecutive cycles; after the cycle that issues M → DRAIN.
  - DRAIN: `rd_en=0`; compare the last returned datum → DONE.
  - DONE: copy the running maximum to `peak_bin`/`peak_mag`, compute `peak_valid`, pulse `done` → IDLE.
- **Output hold:** `peak_bin`, `peak_mag` and `peak_valid` change only in DONE and hold until the next DONE.
- **`start` while busy:** ignored entirely, with no queuing. `start` in the DONE cycle is also ignored.
- **`rd_data` outside a data cycle:** ignored when not in the cycle after an `rd_en`.
- **Reset mid-operation:** an asynchronous abort. The FSM returns to IDLE and all outputs take their reset values. Nothing is written to `peak_*` from the partial scan.

## Timing
- **Reset values:**
  - `rd_en=0`, `rd_addr=0`, `busy=0`, `done=0`
  - `peak_bin=0`, `peak_mag=0`, `peak_valid=0`
  - FSM in IDLE.
- **Cycle numbering:** cycle 0 is the cycle in which `start` is sampled high in IDLE.
- **Address cycles:** cycles 1..M carry `rd_en=1` and `rd_addr = cycle number`.
- **Data cycles:** `rd_data` for bin k is consumed in cycle k+1, so data cycles are 2..M+1.
  - Cycle M+1 is DRAIN.
- **`done`:** high in cycle M+2 = N/2 + 1 (257 for N=512).
- **`busy`:** high in cycles 1..M+2.
- **Next scan:** the earliest accepted `start` is in cycle M+3.
- **Throughput:** one bin per clock with no bubbles.

## Test plan
- **Single tone:** RAM zero except bin 37 = {Re=1000, Im=−500}, `threshold`=0 → `done` in cycle 257; `peak_bin`=37, `peak_mag`=1,250,000, `peak_valid`=1. `rd_addr` runs 1..255 with no gaps, and addresses 0 and ≥256 are never driven.
- **DC and upper half ignored:** bin 0 = {32767, 32767}, bin 300 = {30000, 0}, bin 12 = {100, 0} → `peak_bin`=12, `peak_mag`=10,000.
- **Tie and extremes:**
  - bins 10 and 20 both {−32768, −32768} → `peak_bin`=10, `peak_mag`=0x8000_0000, with no overflow.
- **Threshold and all-zero:**
  - All bins zero, `threshold`=1 → `peak_bin`=1, `peak_mag`=0, `peak_valid`=0.
  - Rerun with `threshold`=0 → `peak_valid`=1.
- **Start while busy:** pulse `start` at cycles 0, 50 and 257 → exactly one `done` (cycle 257), and `busy` low in cycle 258.
- **Reset mid-scan:**
  - Complete one scan (`peak_bin`=37), start a second, assert `reset` at cycle 100 → all outputs 0 immediately.
  - After release, `done` does not pulse until a new `start`; that scan completes normally 257 cycles later.
